ranc_input_injector: RTL and testbench
======================================

# ranc_input_injector

Tick-synchronised packet injector that sits directly upstream of the RANC network grid's west input on core 0. It accepts spike packets from a host over a valid/ready interface and buffers them in a first-word-fall-through FIFO. Packets are grouped per tick by a `last` marker; each group is released to the grid only after a `tick` pulse, through the grid's empty/ren read protocol.

## Interface
- `PACKET_WIDTH`, default 30: packet width (dx 9 + dy 9 + axon 8 + tick 4).
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle pulse that releases the next packet group.
- `host_packet_in`  in  PACKET_WIDTH  packet from the host.
- `host_last`  in  1  marks the final packet of a tick group.
- `host_valid`  in  1  host write request.
- `host_ready`  out  1  FIFO can accept a packet (`!full`).
- `packet_out`  out  PACKET_WIDTH  FIFO head; driven to 0 when `empty_out` = 1.
- `empty_out`  out  1  drives the grid's `input_buffer_empty`.
- `ren_in`  in  1  from the grid's `ren_to_input_buffer`.
- `occupancy`  out  $clog2(DEPTH)+1  number of stored entries.
- `underflow_error`  out  1  sticky error flag.
- `tick_overrun_error`  out  1  sticky error flag.

## Operation
- FIFO entry is `{last, packet}`, PACKET_WIDTH+1 bits wide.
- Push condition: `host_valid & host_ready`.
- Pop condition: `ren_in & !empty_out`.
- FSM has two states:
  - WAIT_TICK: output is gated.
  - DRAIN: output is released.
- `empty_out = fifo_empty | (state != DRAIN)`.
- Transitions:
  - WAIT_TICK → DRAIN on `tick`.
  - DRAIN → WAIT_TICK when the popped entry has `last` = 1, unless `tick` is asserted in the same cycle; then the FSM stays in DRAIN and releases the next group with no error.
- `tick` in DRAIN without a `last` pop in that cycle:
  - sets `tick_overrun_error`;
  - FSM stays in DRAIN;
  - the tick is not queued.
- FIFO empty while in DRAIN: the grid sees `empty_out` = 1 and stalls. Draining resumes as the host pushes the rest of the group.
- `ren_in` while `empty_out` = 1:
  - no pop;
  - sets `underflow_error`;
  - FIFO contents are unchanged.
- Full FIFO: `host_ready` = 0 and no push. Because `host_ready` is registered from occupancy, a pop in the same cycle does not enable a push; `host_ready` rises on the next cycle.
- Push and pop in the same cycle (non-full, non-empty): occupancy is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy saturates by construction, never exceeding DEPTH.
- Reset values: FIFO flushed, pointers 0, occupancy 0, state WAIT_TICK, `empty_out` 1, `packet_out` 0, `host_ready` 1, both errors 0.
- Reset mid-group discards all buffered packets.

## Timing
- Push to visibility: one cycle. An entry written in cycle N is at the head in N+1.
- Tick to release: `tick` in WAIT_TICK at cycle N gives `empty_out` = 0 in N+1 (if the FIFO is non-empty).
- Pop: the head advances at the edge. The new head, or `empty_out` = 1, is visible in the next cycle.
- Last pop at cycle N gives `empty_out` = 1 from N+1 through the next tick.
- `packet_out` is a combinational read of the head register/array.
- Error flags assert the cycle after the offending event and hold until `rst`.

## Configuration
- Macro: `RANC_INJECTOR_STATS_EN`.
- Defined: adds two free-running 32-bit counters, `packets_injected` (pops) and `groups_released` (WAIT_TICK→DRAIN transitions plus same-cycle tick-on-last). Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

## Structure
- Package `ranc_inject_pkg`:
  - state enum `inject_state_t` {WAIT_TICK, DRAIN};
  - default `PACKET_WIDTH` and `DEPTH` localparams;
  - entry typedef (last + packet).
- Sub-module `ranc_inject_fifo`: FWFT FIFO with registered full/occupancy and push/pop ports.
- The top level holds the FSM, gating and error logic.

## Test plan
- **Basic group release:**
  - Stimulus: push 3 packets (0x1, 0x2, 0x3 with last), no tick.
  - Required: `empty_out` stays 1.
  - Stimulus: pulse `tick`, then hold `ren_in` = 1.
  - Required: `packet_out` shows 0x1, 0x2, 0x3 on consecutive cycles, `empty_out` = 1 after the third pop, occupancy 0.
- **Two queued groups:**
  - Stimulus: groups {A, B(last)} and {C(last)} queued; tick, drain.
  - Required: the FSM stops after B with C held. A second tick releases C.
- **Full FIFO:**
  - Stimulus: push DEPTH = 16 entries.
  - Required: `host_ready` = 0 and occupancy 16; a 17th `host_valid` is not accepted.
  - Stimulus: one pop.
  - Required: `host_ready` = 1 the next cycle.
- **Error flags:**
  - Stimulus: `ren_in` = 1 with `empty_out` = 1.
  - Required: `underflow_error` = 1 next cycle, occupancy unchanged.
  - Stimulus: `tick` during DRAIN before the last pop.
  - Required: `tick_overrun_error` = 1.
- **Tick coincident with last pop:**
  - Stimulus: `tick` in the same cycle as the last-entry pop, with the next group queued.
  - Required: state stays DRAIN, no error, the next packet is presented the next cycle.
- **Reset mid-drain:**
  - Stimulus: `rst` asserted mid-drain with 5 entries buffered.
  - Required: next cycle occupancy 0, `empty_out` 1, errors 0, `host_ready` 1.
  - Stimulus: a tick after reset with no pushes.
  - Required: `empty_out` stays 1.

Source files
------------

// File: rtl/ranc_inject_pkg.sv
// ranc_inject_pkg
// Shared types and defaults for the RANC west-input packet injector.
//   inject_state_t  : release FSM state (WAIT_TICK gates output, DRAIN releases it)
//   inject_entry_t  : one buffered FIFO word, {last, packet}, at the default width
//   DEFAULT_*       : default PACKET_WIDTH (dx 9 + dy 9 + axon 8 + tick 4) and FIFO depth
package ranc_inject_pkg;

  localparam int DEFAULT_PACKET_WIDTH = 30;
  localparam int DEFAULT_DEPTH        = 16;

  typedef enum logic {
    WAIT_TICK = 1'b0,
    DRAIN     = 1'b1
  } inject_state_t;

  typedef struct packed {
    logic                            last;
    logic [DEFAULT_PACKET_WIDTH-1:0] packet;
  } inject_entry_t;

endpackage

// File: rtl/ranc_inject_fifo.sv
// ranc_inject_fifo
// First-word-fall-through FIFO. The head word is always visible on rdata.
// full and occupancy are registers, so full reflects the count at the start
// of the cycle: a pop in a full cycle does not open room for a push until the
// next cycle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointers/count to 0)
//   push, wdata   : write request and data (ignored while full)
//   pop           : read request (ignored while empty)
//   rdata         : head word
//   empty, full   : status
//   occupancy     : number of stored words, 0..DEPTH
module ranc_inject_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & (count != '0);

  // Simultaneous push and pop leaves the count unchanged; the count can never
  // pass DEPTH because pushes are blocked while full.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count  <= count_next;
      full_q <= (count_next == CW'(DEPTH));
    end
  end

  assign rdata     = mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = full_q;
  assign occupancy = count;

endmodule

// File: rtl/ranc_input_injector.sv
// ranc_input_injector
// Tick-synchronised spike packet injector feeding the west input of RANC
// core 0. Host packets are buffered as {last, packet}; each group (ending in
// a last-marked packet) is released to the grid only after a tick pulse.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   tick                           : one-cycle pulse releasing the next group
//   host_packet_in/host_last/host_valid/host_ready : host write channel
//   packet_out, empty_out, ren_in  : grid read side (input_buffer_empty / ren)
//   occupancy                      : stored entries
//   underflow_error                : sticky, ren_in seen while empty_out = 1
//   tick_overrun_error             : sticky, tick seen mid-group in DRAIN
//   state_dbg                      : current release FSM state
//   packets_injected, groups_released : 32-bit wrapping counters, present
//                                    only with RANC_INJECTOR_STATS_EN defined
//
// Handshakes: a host word transfers on a rising edge where host_valid and
// host_ready are both 1; host_ready depends only on registered state. A grid
// word transfers on a rising edge where ren_in = 1 and empty_out = 0; ren_in
// with empty_out = 1 transfers nothing and is flagged as an underflow.
module ranc_input_injector
  import ranc_inject_pkg::*;
#(
  parameter int PACKET_WIDTH = DEFAULT_PACKET_WIDTH,
  parameter int DEPTH        = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [PACKET_WIDTH-1:0] host_packet_in,
  input  logic                    host_last,
  input  logic                    host_valid,
  output logic                    host_ready,
  output logic [PACKET_WIDTH-1:0] packet_out,
  output logic                    empty_out,
  input  logic                    ren_in,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    underflow_error,
  output logic                    tick_overrun_error,
  output inject_state_t           state_dbg
`ifdef RANC_INJECTOR_STATS_EN
  ,
  output logic [31:0]             packets_injected,
  output logic [31:0]             groups_released
`endif
);

  inject_state_t       state;
  logic [PACKET_WIDTH:0] fifo_wdata;
  logic [PACKET_WIDTH:0] fifo_rdata;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                popped_last;

  assign fifo_wdata  = {host_last, host_packet_in};
  assign host_ready  = ~fifo_full;
  assign push        = host_valid & host_ready;
  assign empty_out   = fifo_empty | (state != DRAIN);
  assign pop         = ren_in & ~empty_out;
  assign popped_last = pop & fifo_rdata[PACKET_WIDTH];
  assign packet_out  = empty_out ? '0 : fifo_rdata[PACKET_WIDTH-1:0];
  assign state_dbg   = state;

  ranc_inject_fifo #(
    .WIDTH (PACKET_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wdata     (fifo_wdata),
    .pop       (pop),
    .rdata     (fifo_rdata),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .occupancy (occupancy)
  );

  // Release FSM and sticky error flags. A tick arriving on the same edge as
  // the last pop of a group chains straight into the next group; any other
  // tick during DRAIN is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= WAIT_TICK;
      underflow_error    <= 1'b0;
      tick_overrun_error <= 1'b0;
    end else begin
      if (ren_in && empty_out) begin
        underflow_error <= 1'b1;
      end
      case (state)
        WAIT_TICK: begin
          if (tick) state <= DRAIN;
        end
        DRAIN: begin
          if (popped_last) begin
            if (!tick) state <= WAIT_TICK;
          end else if (tick) begin
            tick_overrun_error <= 1'b1;
          end
        end
        default: state <= WAIT_TICK;
      endcase
    end
  end

`ifdef RANC_INJECTOR_STATS_EN
  logic group_release;
  assign group_release = tick & ((state == WAIT_TICK) | popped_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      packets_injected <= '0;
      groups_released  <= '0;
    end else begin
      if (pop)           packets_injected <= packets_injected + 32'd1;
      if (group_release) groups_released  <= groups_released + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ranc_input_injector.sv
// tb_ranc_input_injector
// Directed scenarios plus a randomized run for ranc_input_injector, checked
// against a queue-based model of the release rules. Build with
// RANC_INJECTOR_STATS_EN defined to also cover the statistics counters.
module tb_ranc_input_injector;
  import ranc_inject_pkg::*;

  localparam int PW    = 30;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [PW-1:0] host_packet_in = '0;
  logic          host_last = 1'b0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic [PW-1:0] packet_out;
  logic          empty_out;
  logic          ren_in = 1'b0;
  logic [4:0]    occupancy;
  logic          underflow_error;
  logic          tick_overrun_error;
  inject_state_t state_dbg;
`ifdef RANC_INJECTOR_STATS_EN
  logic [31:0]   packets_injected;
  logic [31:0]   groups_released;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: buffered entries, release gate, sticky flags, counters.
  inject_entry_t mq[$];
  bit            m_open = 1'b0;
  bit            m_uf   = 1'b0;
  bit            m_ov   = 1'b0;
  int unsigned   m_pops   = 0;
  int unsigned   m_groups = 0;

  ranc_input_injector #(.PACKET_WIDTH(PW), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .tick               (tick),
    .host_packet_in     (host_packet_in),
    .host_last          (host_last),
    .host_valid         (host_valid),
    .host_ready         (host_ready),
    .packet_out         (packet_out),
    .empty_out          (empty_out),
    .ren_in             (ren_in),
    .occupancy          (occupancy),
    .underflow_error    (underflow_error),
    .tick_overrun_error (tick_overrun_error),
    .state_dbg          (state_dbg)
`ifdef RANC_INJECTOR_STATS_EN
    ,
    .packets_injected   (packets_injected),
    .groups_released    (groups_released)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  // Advance one clock edge with the currently driven inputs and update the
  // model. Outputs are then stable for checking (#1 after the edge).
  task automatic cycle();
    bit gated, do_pop, do_push, plast, c_rst, c_tick, c_ren, rel;
    inject_entry_t e;
    c_rst   = rst;
    c_tick  = tick;
    c_ren   = ren_in;
    gated   = (mq.size() == 0) || !m_open;
    do_pop  = c_ren && !gated;
    do_push = host_valid && (mq.size() < DEPTH);
    plast   = do_pop && mq[0].last;
    e.last   = host_last;
    e.packet = host_packet_in;
    @(posedge clk);
    #1;
    if (c_rst) begin
      mq.delete();
      m_open = 1'b0; m_uf = 1'b0; m_ov = 1'b0; m_pops = 0; m_groups = 0;
    end else begin
      rel = 1'b0;
      if (c_ren && gated) m_uf = 1'b1;
      if (!m_open) begin
        if (c_tick) begin m_open = 1'b1; rel = 1'b1; end
      end else if (plast) begin
        if (c_tick) rel = 1'b1; else m_open = 1'b0;
      end else if (c_tick) begin
        m_ov = 1'b1;
      end
      if (rel) m_groups++;
      if (do_pop) begin mq.delete(0); m_pops++; end
      if (do_push) mq.push_back(e);
    end
  endtask

  task automatic step(input bit v, input logic [PW-1:0] p, input bit l,
                      input bit t, input bit r);
    host_valid     = v;
    host_packet_in = p;
    host_last      = l;
    tick           = t;
    ren_in         = r;
    cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty_out); end
    checks++; if (packet_out !== '0) begin errors++; $display("FAIL reset_pkt got=%h exp=0", packet_out); end
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", host_ready); end
    checks++; if ({underflow_error, tick_overrun_error} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b%b exp=00", underflow_error, tick_overrun_error); end
    checks++; if (state_dbg !== WAIT_TICK) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_basic_group();
    apply_reset();
    step(1, 30'h1, 0, 0, 0);
    step(1, 30'h2, 0, 0, 0);
    step(1, 30'h3, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL basic_gated got=%b exp=1", empty_out); end
    checks++; if (occupancy !== 5'd3) begin errors++; $display("FAIL basic_occ3 got=%0d exp=3", occupancy); end
    step(0, '0, 0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      checks++; if (empty_out !== 1'b0 || packet_out !== PW'(k)) begin errors++; $display("FAIL basic_head got=%h/%b exp=%h/0", packet_out, empty_out, k); end
      step(0, '0, 0, 0, 1);
    end
    checks++; if (empty_out !== 1'b1 || occupancy !== 5'd0) begin errors++; $display("FAIL basic_done got=%b/%0d exp=1/0", empty_out, occupancy); end
    checks++; if (state_dbg !== WAIT_TICK) begin errors++; $display("FAIL basic_state got=%0d exp=0", state_dbg); end
    step(0, '0, 0, 0, 0);
  endtask

  task automatic test_two_groups();
    apply_reset();
    step(1, 30'hA, 0, 0, 0);
    step(1, 30'hB, 1, 0, 0);
    step(1, 30'hC, 1, 0, 0);
    step(0, '0, 0, 1, 0);
    checks++; if (packet_out !== 30'hA) begin errors++; $display("FAIL two_a got=%h exp=a", packet_out); end
    step(0, '0, 0, 0, 1);
    checks++; if (packet_out !== 30'hB) begin errors++; $display("FAIL two_b got=%h exp=b", packet_out); end
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 0);
    checks++; if (empty_out !== 1'b1 || occupancy !== 5'd1) begin errors++; $display("FAIL two_held got=%b/%0d exp=1/1", empty_out, occupancy); end
    step(0, '0, 0, 1, 0);
    checks++; if (empty_out !== 1'b0 || packet_out !== 30'hC) begin errors++; $display("FAIL two_c got=%h/%b exp=c/0", packet_out, empty_out); end
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 0);
    checks++; if (empty_out !== 1'b1 || occupancy !== 5'd0 || underflow_error !== 1'b0) begin errors++; $display("FAIL two_end got=%b/%0d/%b exp=1/0/0", empty_out, occupancy, underflow_error); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(1, PW'(i), (i == DEPTH - 1), 0, 0);
    checks++; if (host_ready !== 1'b0 || occupancy !== 5'd16) begin errors++; $display("FAIL full_flag got=%b/%0d exp=0/16", host_ready, occupancy); end
    step(1, 30'h99, 1, 0, 0);
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_reject got=%0d exp=16", occupancy); end
    step(0, '0, 0, 1, 0);
    checks++; if (packet_out !== 30'h0) begin errors++; $display("FAIL full_head0 got=%h exp=0", packet_out); end
    // Pop and push together while full: only the pop happens.
    step(1, 30'h77, 1, 0, 1);
    checks++; if (host_ready !== 1'b1 || occupancy !== 5'd15) begin errors++; $display("FAIL full_reopen got=%b/%0d exp=1/15", host_ready, occupancy); end
    step(1, 30'h77, 1, 0, 0);
    checks++; if (host_ready !== 1'b0 || occupancy !== 5'd16) begin errors++; $display("FAIL full_refill got=%b/%0d exp=0/16", host_ready, occupancy); end
    for (int k = 1; k < DEPTH; k++) begin
      checks++; if (packet_out !== PW'(k)) begin errors++; $display("FAIL full_order got=%h exp=%h", packet_out, k); end
      step(0, '0, 0, 0, 1);
    end
    checks++; if (empty_out !== 1'b1 || occupancy !== 5'd1) begin errors++; $display("FAIL full_gap got=%b/%0d exp=1/1", empty_out, occupancy); end
    step(0, '0, 0, 1, 0);
    checks++; if (packet_out !== 30'h77) begin errors++; $display("FAIL full_tail got=%h exp=77", packet_out); end
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 0);
  endtask

  task automatic test_errors();
    apply_reset();
    step(1, 30'h21, 0, 0, 0);
    step(1, 30'h22, 1, 0, 0);
    step(0, '0, 0, 0, 1);
    checks++; if (underflow_error !== 1'b1 || occupancy !== 5'd2) begin errors++; $display("FAIL err_uf got=%b/%0d exp=1/2", underflow_error, occupancy); end
    step(0, '0, 0, 1, 0);
    checks++; if (tick_overrun_error !== 1'b0 || packet_out !== 30'h21) begin errors++; $display("FAIL err_release got=%b/%h exp=0/21", tick_overrun_error, packet_out); end
    step(0, '0, 0, 1, 0);
    checks++; if (tick_overrun_error !== 1'b1 || state_dbg !== DRAIN || occupancy !== 5'd2) begin errors++; $display("FAIL err_ov got=%b/%0d/%0d exp=1/1/2", tick_overrun_error, state_dbg, occupancy); end
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 0);
    checks++; if (underflow_error !== 1'b1 || empty_out !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b/%b exp=1/1", underflow_error, empty_out); end
  endtask

  task automatic test_tick_on_last();
    apply_reset();
    step(1, 30'h31, 1, 0, 0);
    step(1, 30'h32, 1, 0, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    checks++; if (state_dbg !== DRAIN || empty_out !== 1'b0 || packet_out !== 30'h32) begin errors++; $display("FAIL chain_next got=%0d/%b/%h exp=1/0/32", state_dbg, empty_out, packet_out); end
    checks++; if ({underflow_error, tick_overrun_error} !== 2'b00) begin errors++; $display("FAIL chain_err got=%b%b exp=00", underflow_error, tick_overrun_error); end
    step(0, '0, 0, 0, 1);
    checks++; if (empty_out !== 1'b1 || state_dbg !== WAIT_TICK) begin errors++; $display("FAIL chain_end got=%b/%0d exp=1/0", empty_out, state_dbg); end
    step(0, '0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    for (int i = 0; i < 6; i++) step(1, PW'(32'h40 + i), (i == 5), 0, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 1, 0);
    checks++; if (occupancy !== 5'd5 || tick_overrun_error !== 1'b1) begin errors++; $display("FAIL mid_pre got=%0d/%b exp=5/1", occupancy, tick_overrun_error); end
    rst = 1'b1;
    step(0, '0, 0, 0, 0);
    rst = 1'b0;
    checks++; if (occupancy !== 5'd0 || empty_out !== 1'b1 || host_ready !== 1'b1) begin errors++; $display("FAIL mid_rst got=%0d/%b/%b exp=0/1/1", occupancy, empty_out, host_ready); end
    checks++; if ({underflow_error, tick_overrun_error} !== 2'b00 || packet_out !== '0) begin errors++; $display("FAIL mid_rst_err got=%b%b/%h exp=00/0", underflow_error, tick_overrun_error, packet_out); end
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
    checks++; if (empty_out !== 1'b1 || occupancy !== 5'd0) begin errors++; $display("FAIL mid_tick got=%b/%0d exp=1/0", empty_out, occupancy); end
  endtask

  task automatic test_random();
    bit exp_empty;
    logic [PW-1:0] exp_pkt;
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 3) != 0, PW'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
      exp_empty = (mq.size() == 0) || !m_open;
      exp_pkt   = exp_empty ? '0 : mq[0].packet;
      checks++; if (occupancy !== 5'(mq.size())) begin errors++; $display("FAIL rnd_occ n=%0d got=%0d exp=%0d", n, occupancy, mq.size()); end
      checks++; if (empty_out !== exp_empty || packet_out !== exp_pkt) begin errors++; $display("FAIL rnd_out n=%0d got=%b/%h exp=%b/%h", n, empty_out, packet_out, exp_empty, exp_pkt); end
      checks++; if (host_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, host_ready, mq.size() < DEPTH); end
      checks++; if (underflow_error !== m_uf || tick_overrun_error !== m_ov) begin errors++; $display("FAIL rnd_err n=%0d got=%b%b exp=%b%b", n, underflow_error, tick_overrun_error, m_uf, m_ov); end
    end
`ifdef RANC_INJECTOR_STATS_EN
    checks++; if (packets_injected !== m_pops) begin errors++; $display("FAIL stats_pops got=%0d exp=%0d", packets_injected, m_pops); end
    checks++; if (groups_released !== m_groups) begin errors++; $display("FAIL stats_groups got=%0d exp=%0d", groups_released, m_groups); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_group();
    test_two_groups();
    test_full();
    test_errors();
    test_tick_on_last();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
